// File: rtl/acc_pkg.sv
// Shared encodings and defaults for the accumulator memory-access unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acc_pkg;

    // Address source select
    localparam logic [1:0] ASEL_PC    = 2'd0;
    localparam logic [1:0] ASEL_IR    = 2'd1;
    localparam logic [1:0] ASEL_STACK = 2'd2;
    localparam logic [1:0] ASEL_ALU   = 2'd3;

    // Write data source select
    localparam logic DSEL_ACC = 1'b0;
    localparam logic DSEL_PC  = 1'b1;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    // Default memory map constants
    localparam logic [15:0] IO_ADDR_DEFAULT    = 16'hFFFE;
    localparam logic [15:0] STACK_ADDR_DEFAULT = 16'h07FE;

endpackage

// File: rtl/acc_ram.sv
// Single-port synchronous RAM, one write enable, no reset on contents.
// Latency: read data registered, valid one cycle after the address edge.
// Backpressure: none; accepts an access every cycle.
module acc_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write on enable; read port always returns the pre-write word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/acc_mem_unit.sv
// Memory-access unit: address/data muxing, wait-state sequencing, I/O decode, IR/MDR latching.
// Latency: Done asserts WAIT_STATES+1 cycles after the accepting edge; results land at end of Done cycle.
// Backpressure: Busy high from acceptance through the Done cycle; Req ignored while Busy.
module acc_mem_unit
    import acc_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] IO_ADDR     = IO_ADDR_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] STACK_ADDR  = STACK_ADDR_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Req,
    input  logic                  We,
    input  logic [1:0]            AddrSel,
    input  logic                  DataSel,
    input  logic                  IRWrite,
    input  logic [DATA_WIDTH-1:0] PC,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic [DATA_WIDTH-1:0] ACC,
    input  logic [DATA_WIDTH-1:0] ALUOut,
    input  logic [DATA_WIDTH-1:0] IOIn,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] IROut,
    output logic [DATA_WIDTH-1:0] MDROut,
    output logic [DATA_WIDTH-1:0] IOOut,
    output logic [DATA_WIDTH-1:0] MemOut
);

    state_t                state;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  irw_q;

    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  is_io;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] rd_val;

    // Address and write-data source selection, consumed only at acceptance
    always_comb begin
        sel_addr = PC;
        case (AddrSel)
            ASEL_PC:    sel_addr = PC;
            ASEL_IR:    sel_addr = IR;
            ASEL_STACK: sel_addr = STACK_ADDR;
            default:    sel_addr = ALUOut;
        endcase
        sel_data = (DataSel == DSEL_PC) ? PC : ACC;
    end

    // Full-width match selects the I/O port; RAM aliases on the low bits otherwise.
    // In IDLE the RAM is addressed straight from the mux so a zero-wait read has
    // its word registered by the time COMPLETE begins.
    assign is_io    = (addr_q == IO_ADDR);
    assign ram_addr = (state == ST_IDLE) ? sel_addr[ADDR_WIDTH-1:0] : addr_q[ADDR_WIDTH-1:0];
    assign ram_we   = (state == ST_COMPLETE) && we_q && !is_io;
    assign rd_val   = is_io ? IOIn : ram_rdata;

    acc_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Access sequencer: capture on accept, count wait states, commit results in COMPLETE
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            irw_q   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            IROut   <= '0;
            MDROut  <= '0;
            IOOut   <= '0;
            MemOut  <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Req) begin
                        addr_q  <= sel_addr;
                        wdata_q <= sel_data;
                        we_q    <= We;
                        irw_q   <= IRWrite;
                        cnt     <= 4'(WAIT_STATES);
                        Busy    <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state <= ST_COMPLETE;
                            Done  <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_COMPLETE;
                        Done  <= 1'b1;
                    end
                end
                ST_COMPLETE: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                    if (we_q) begin
                        if (is_io) begin
                            IOOut <= wdata_q;
                        end
                    end else begin
                        MDROut <= rd_val;
                        MemOut <= rd_val;
                        if (irw_q) begin
                            IROut <= rd_val;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_mem_unit.sv
// Bench for acc_mem_unit: four instances with WAIT_STATES 0/1/3/15 sharing all inputs but Req.
// Each access is predicted by a word-level memory/register model and checked on completion.
// Stimulus mixes directed scenarios with randomized accesses over an aliasing address pool.
`timescale 1ns/1ps
module tb_acc_mem_unit;

    localparam int          N     = 4;
    localparam int          WS [N] = '{0, 1, 3, 15};
    localparam logic [15:0] IO_A  = 16'hFFFE;
    localparam logic [15:0] STK_A = 16'h07FE;
    localparam logic [9:0]  POOL [6] = '{10'h000, 10'h010, 10'h155, 10'h2AA, 10'h3FE, 10'h3FF};

    typedef struct packed {
        logic        we;
        logic [1:0]  asel;
        logic        dsel;
        logic        irw;
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] acc;
        logic [15:0] alu;
    } txn_t;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [N-1:0] req;
    logic        We, DataSel, IRWrite;
    logic [1:0]  AddrSel;
    logic [15:0] PC, IR, ACC, ALUOut, IOIn;
    logic [N-1:0] busy, done;
    logic [15:0] ir_out [N];
    logic [15:0] mdr_out [N];
    logic [15:0] io_out [N];
    logic [15:0] mem_out [N];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_mem [N][1024];
    logic [15:0] m_ir  [N];
    logic [15:0] m_mdr [N];
    logic [15:0] m_io  [N];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < N; g++) begin : g_dut
        acc_mem_unit #(.WAIT_STATES(WS[g])) u_dut (
            .CLK     (CLK),
            .Reset   (Reset),
            .Req     (req[g]),
            .We      (We),
            .AddrSel (AddrSel),
            .DataSel (DataSel),
            .IRWrite (IRWrite),
            .PC      (PC),
            .IR      (IR),
            .ACC     (ACC),
            .ALUOut  (ALUOut),
            .IOIn    (IOIn),
            .Busy    (busy[g]),
            .Done    (done[g]),
            .IROut   (ir_out[g]),
            .MDROut  (mdr_out[g]),
            .IOOut   (io_out[g]),
            .MemOut  (mem_out[g])
        );
    end

    function automatic txn_t rnd_txn();
        txn_t t;
        t.we   = 1'($urandom);
        t.asel = 2'($urandom);
        t.dsel = 1'($urandom);
        t.irw  = 1'($urandom);
        t.pc   = 16'($urandom);
        t.ir   = 16'($urandom);
        t.acc  = 16'($urandom);
        t.alu  = 16'($urandom);
        return t;
    endfunction

    function automatic logic [15:0] t_addr(input txn_t t);
        case (t.asel)
            2'd0:    return t.pc;
            2'd1:    return t.ir;
            2'd2:    return STK_A;
            default: return t.alu;
        endcase
    endfunction

    task automatic drive(input txn_t t);
        We = t.we; AddrSel = t.asel; DataSel = t.dsel; IRWrite = t.irw;
        PC = t.pc; IR = t.ir; ACC = t.acc; ALUOut = t.alu;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_ir[k] = '0; m_mdr[k] = '0; m_io[k] = '0;
        end
    endtask

    task automatic check_regs(input int k, input string tag);
        checks++; if (mdr_out[k] !== m_mdr[k]) begin errors++; $display("FAIL %s mdr[%0d]: got %h want %h", tag, k, mdr_out[k], m_mdr[k]); end
        checks++; if (mem_out[k] !== m_mdr[k]) begin errors++; $display("FAIL %s memout[%0d]: got %h want %h", tag, k, mem_out[k], m_mdr[k]); end
        checks++; if (ir_out[k] !== m_ir[k]) begin errors++; $display("FAIL %s ir[%0d]: got %h want %h", tag, k, ir_out[k], m_ir[k]); end
        checks++; if (io_out[k] !== m_io[k]) begin errors++; $display("FAIL %s io[%0d]: got %h want %h", tag, k, io_out[k], m_io[k]); end
    endtask

    // One full access on instance k, entered and left at a negedge
    task automatic do_access(input int k, input txn_t t, input logic [15:0] io_val,
                             input bit scram, input bit poke, input string tag);
        logic [15:0] a, d, rv;
        int n;
        a = t_addr(t);
        d = t.dsel ? t.pc : t.acc;
        drive(t);
        IOIn   = io_val;
        req[k] = 1'b1;
        @(negedge CLK);
        req[k] = 1'b0;
        n = 1;
        while (done[k] !== 1'b1 && n <= 40) begin
            checks++;
            if (busy[k] !== 1'b1) begin errors++; $display("FAIL %s busy_wait[%0d]: got %b want 1", tag, k, busy[k]); end
            if (scram) begin drive(rnd_txn()); IOIn = 16'($urandom); end
            if (poke) req[k] = 1'($urandom);
            @(negedge CLK);
            n++;
        end
        req[k] = 1'b0;
        checks++;
        if (n != WS[k] + 1) begin errors++; $display("FAIL %s latency[%0d]: got %0d want %0d", tag, k, n, WS[k] + 1); end
        checks++;
        if (busy[k] !== 1'b1) begin errors++; $display("FAIL %s busy_done[%0d]: got %b want 1", tag, k, busy[k]); end
        if (t.we) begin
            if (a == IO_A) m_io[k] = d;
            else           m_mem[k][a[9:0]] = d;
        end else begin
            rv = (a == IO_A) ? IOIn : m_mem[k][a[9:0]];
            m_mdr[k] = rv;
            if (t.irw) m_ir[k] = rv;
        end
        @(negedge CLK);
        checks++;
        if (done[k] !== 1'b0) begin errors++; $display("FAIL %s done_pulse[%0d]: got %b want 0", tag, k, done[k]); end
        checks++;
        if (busy[k] !== 1'b0) begin errors++; $display("FAIL %s busy_idle[%0d]: got %b want 0", tag, k, busy[k]); end
        check_regs(k, tag);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        req = '0;
        drive(rnd_txn());
        IOIn = '0;
        #2 Reset = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        for (int k = 0; k < N; k++) begin
            checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset busy[%0d]: got %b want 0", k, busy[k]); end
            checks++; if (done[k] !== 1'b0) begin errors++; $display("FAIL reset done[%0d]: got %b want 0", k, done[k]); end
            check_regs(k, "reset");
        end
        Reset = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_write_read();
        txn_t t;
        t = rnd_txn(); t.we = 1; t.asel = 2'd3; t.dsel = 0; t.acc = 16'h1234; t.alu = 16'h0010;
        do_access(1, t, 16'($urandom), 0, 0, "wr_alu");
        t = rnd_txn(); t.we = 0; t.asel = 2'd0; t.irw = 1; t.pc = 16'h0010;
        do_access(1, t, 16'($urandom), 0, 0, "rd_pc");
        checks++;
        if (ir_out[1] !== 16'h1234 || mdr_out[1] !== 16'h1234) begin
            errors++; $display("FAIL rd_pc_const: got ir %h mdr %h want 1234", ir_out[1], mdr_out[1]);
        end
    endtask

    task automatic test_io();
        txn_t t;
        t = rnd_txn(); t.we = 1; t.asel = 2'd3; t.dsel = 0; t.acc = 16'h5A5A; t.alu = 16'h03FE;
        do_access(1, t, 16'($urandom), 0, 0, "wr_3fe");
        t = rnd_txn(); t.we = 1; t.asel = 2'd3; t.dsel = 0; t.acc = 16'hBEEF; t.alu = 16'hFFFE;
        do_access(1, t, 16'($urandom), 0, 0, "wr_io");
        checks++;
        if (io_out[1] !== 16'hBEEF) begin errors++; $display("FAIL io_out_const: got %h want beef", io_out[1]); end
        t = rnd_txn(); t.we = 0; t.asel = 2'd3; t.irw = 0; t.alu = 16'h03FE;
        do_access(1, t, 16'($urandom), 0, 0, "rd_3fe");
        checks++;
        if (mdr_out[1] !== 16'h5A5A) begin errors++; $display("FAIL ram_3fe_kept: got %h want 5a5a", mdr_out[1]); end
        t = rnd_txn(); t.we = 0; t.asel = 2'd1; t.irw = 0; t.ir = 16'hFFFE;
        do_access(1, t, 16'h00A5, 0, 0, "rd_io");
        checks++;
        if (mdr_out[1] !== 16'h00A5) begin errors++; $display("FAIL rd_io_const: got %h want 00a5", mdr_out[1]); end
    endtask

    task automatic test_stack_alias();
        txn_t t;
        t = rnd_txn(); t.we = 1; t.asel = 2'd2; t.dsel = 1; t.pc = 16'h0042;
        do_access(1, t, 16'($urandom), 0, 0, "wr_stack");
        t = rnd_txn(); t.we = 0; t.asel = 2'd2; t.irw = 0;
        do_access(1, t, 16'($urandom), 0, 0, "rd_stack");
        checks++;
        if (mdr_out[1] !== 16'h0042) begin errors++; $display("FAIL rd_stack_const: got %h want 0042", mdr_out[1]); end
        t = rnd_txn(); t.we = 0; t.asel = 2'd0; t.irw = 0; t.pc = 16'h0410;
        do_access(1, t, 16'($urandom), 0, 0, "rd_alias");
        checks++;
        if (mdr_out[1] !== 16'h1234) begin errors++; $display("FAIL rd_alias_const: got %h want 1234", mdr_out[1]); end
    endtask

    task automatic test_reset_mid_access();
        txn_t t;
        t = rnd_txn(); t.we = 1; t.asel = 2'd3; t.dsel = 0; t.acc = 16'h1111; t.alu = 16'h0123;
        do_access(2, t, 16'($urandom), 1, 0, "pre_wr");
        t = rnd_txn(); t.we = 1; t.asel = 2'd3; t.dsel = 0; t.acc = 16'h7777; t.alu = IO_A;
        do_access(2, t, 16'($urandom), 1, 0, "pre_io");
        t = rnd_txn(); t.we = 0; t.asel = 2'd3; t.irw = 1; t.alu = 16'h0123;
        do_access(2, t, 16'($urandom), 1, 0, "pre_rd");
        t = rnd_txn(); t.we = 1; t.asel = 2'd3; t.dsel = 0; t.acc = 16'h2222; t.alu = 16'h0123;
        drive(t);
        req[2] = 1'b1;
        @(negedge CLK);
        req[2] = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < N; k++) begin
            checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL abort busy[%0d]: got %b want 0", k, busy[k]); end
            checks++; if (done[k] !== 1'b0) begin errors++; $display("FAIL abort done[%0d]: got %b want 0", k, done[k]); end
            check_regs(k, "abort");
        end
        @(negedge CLK);
        Reset = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            checks++; if (done[2] !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", done[2]); end
        end
        t = rnd_txn(); t.we = 0; t.asel = 2'd3; t.irw = 0; t.alu = 16'h0123;
        do_access(2, t, 16'($urandom), 0, 0, "post_abort_rd");
        checks++;
        if (mdr_out[2] !== 16'h1111) begin errors++; $display("FAIL abort_old_word: got %h want 1111", mdr_out[2]); end
    endtask

    task automatic test_back_to_back();
        txn_t t;
        int ndone;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            t = rnd_txn(); t.we = 1; t.asel = 2'd3; t.dsel = 0; t.alu = 16'h0100 + 16'(i / 2);
            drive(t);
            if (i % 2 == 0) m_mem[0][t.alu[9:0]] = t.acc;
            req[0] = 1'b1;
            @(negedge CLK);
            checks++;
            if (done[0] !== 1'(i % 2 == 0)) begin errors++; $display("FAIL b2b done cyc %0d: got %b want %b", i, done[0], i % 2 == 0); end
            checks++;
            if (busy[0] !== done[0]) begin errors++; $display("FAIL b2b busy cyc %0d: got %b want %b", i, busy[0], done[0]); end
            if (done[0] === 1'b1) ndone++;
        end
        req[0] = 1'b0;
        checks++;
        if (ndone != 8) begin errors++; $display("FAIL b2b count: got %0d want 8", ndone); end
        for (int j = 0; j < 8; j++) begin
            t = rnd_txn(); t.we = 0; t.asel = 2'd1; t.irw = 0; t.ir = 16'h0100 + 16'(j);
            do_access(0, t, 16'($urandom), 0, 0, "b2b_rd");
        end
    endtask

    task automatic test_long_wait();
        txn_t t;
        t = rnd_txn(); t.we = 1; t.asel = 2'd3; t.dsel = 0; t.acc = 16'hC0DE; t.alu = 16'h0055;
        do_access(3, t, 16'($urandom), 1, 1, "ws15_wr");
        t = rnd_txn(); t.we = 0; t.asel = 2'd3; t.irw = 1; t.alu = 16'h0055;
        do_access(3, t, 16'($urandom), 1, 1, "ws15_rd");
    endtask

    task automatic test_random();
        txn_t t;
        logic [15:0] a;
        for (int k = 0; k < N; k++) begin
            for (int p = 0; p < 6; p++) begin
                t = rnd_txn(); t.we = 1; t.asel = 2'd3; t.alu = {6'd0, POOL[p]};
                do_access(k, t, 16'($urandom), 1, 0, "rnd_fill");
            end
            for (int r = 0; r < 20; r++) begin
                t = rnd_txn();
                a = ($urandom_range(0, 7) == 0) ? IO_A : {6'($urandom), POOL[$urandom_range(0, 5)]};
                case (t.asel)
                    2'd0:    t.pc  = a;
                    2'd1:    t.ir  = a;
                    2'd3:    t.alu = a;
                    default: ;
                endcase
                do_access(k, t, 16'($urandom), 1, 1, "rnd");
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_io();
        test_stack_alias();
        test_reset_mid_access();
        test_back_to_back();
        test_long_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
